test_unit_seq: RTL and testbench

Sequencer that sits directly upstream of a bank of test units. It fires each unit's start pulse in turn, waits for that unit's done/pass response under a watchdog, and tallies pass, fail and timeout results. When the last unit completes it emits a one-cycle finish pulse and a sticky all-pass flag for the testbench top.

---
 rtl/test_unit_pkg.sv | 18 +
 rtl/test_unit_watchdog.sv | 33 +++
 rtl/test_unit_seq.sv | 162 ++++++++++++++++
 tb/tb_test_unit_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_unit_pkg.sv
// Shared types and helpers for the test-unit sequencer.
// Holds the sequencer state enum and the counter-width function.
package test_unit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        GAP,
        DONE
    } test_unit_seq_state_e;

    // Width needed to hold a count from 0 to n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/test_unit_watchdog.sv
// Per-unit watchdog for the test-unit sequencer.
// Ports: clock, rst (sync, active-high), clear (restart count),
//        enable (count while waiting), expired (last allowed cycle).
module test_unit_watchdog
    import test_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] LAST = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] count;

    always_ff @(posedge clock) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + WW'(1);
        end
    end

    // Asserted in the final permitted wait cycle, so the wait spans
    // exactly TIMEOUT_CYCLES cycles.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/test_unit_seq.sv
// Sequencer that starts each test unit in turn, tallies pass/fail/timeout
// and reports a finish pulse plus a sticky all-pass flag.
// Ports: clock, rst (sync, active-high), run, unit_start/unit_done/unit_pass
//        per unit, busy, finish, all_pass, pass_cnt, fail_cnt, timeout_cnt,
//        fail_vec, cur_idx. Watchdog present only with TEST_UNIT_SEQ_TIMEOUT_EN.
module test_unit_seq
    import test_unit_pkg::*;
#(
    parameter int NUM_UNITS      = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int GAP_CYCLES     = 2,
    localparam int CW = cnt_w(NUM_UNITS),
    localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 run,
    output logic [NUM_UNITS-1:0] unit_start,
    input  logic [NUM_UNITS-1:0] unit_done,
    input  logic [NUM_UNITS-1:0] unit_pass,
    output logic                 busy,
    output logic                 finish,
    output logic                 all_pass,
    output logic [CW-1:0]        pass_cnt,
    output logic [CW-1:0]        fail_cnt,
    output logic [CW-1:0]        timeout_cnt,
    output logic [NUM_UNITS-1:0] fail_vec,
    output logic [IW-1:0]        cur_idx
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_UNITS - 1);

    test_unit_seq_state_e state;
    test_unit_seq_state_e state_n;

    logic [GW-1:0]        gap_cnt;
    logic [IW-1:0]        idx_n;
    logic [CW-1:0]        pass_n;
    logic [CW-1:0]        fail_n;
    logic [CW-1:0]        to_n;
    logic [NUM_UNITS-1:0] vec_n;
    logic                 all_pass_n;
    logic                 hit_done;
    logic                 hit_to;
    logic                 expired;

`ifdef TEST_UNIT_SEQ_TIMEOUT_EN
    test_unit_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .rst    (rst),
        .clear  (state == START),
        .enable (state == WAIT),
        .expired(expired)
    );
`else
    // No watchdog: a unit may wait forever. The compare only keeps the
    // parameter referenced; it is false for any legal value.
    assign expired = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_n    = state;
        idx_n      = cur_idx;
        pass_n     = pass_cnt;
        fail_n     = fail_cnt;
        to_n       = timeout_cnt;
        vec_n      = fail_vec;
        all_pass_n = all_pass;
        hit_done   = 1'b0;
        hit_to     = 1'b0;
        unique case (state)
            IDLE: begin
                if (run) begin
                    state_n    = START;
                    idx_n      = '0;
                    pass_n     = '0;
                    fail_n     = '0;
                    to_n       = '0;
                    vec_n      = '0;
                    all_pass_n = 1'b0;
                end
            end
            START: begin
                state_n = WAIT;
            end
            WAIT: begin
                // A done in the expiry cycle wins over the watchdog.
                hit_done = unit_done[cur_idx];
                hit_to   = !hit_done && expired;
                if (hit_done) begin
                    if (unit_pass[cur_idx]) begin
                        pass_n = pass_cnt + CW'(1);
                    end else begin
                        fail_n         = fail_cnt + CW'(1);
                        vec_n[cur_idx] = 1'b1;
                    end
                end
                if (hit_to) begin
                    to_n           = timeout_cnt + CW'(1);
                    vec_n[cur_idx] = 1'b1;
                end
                if (hit_done || hit_to) begin
                    if (cur_idx == IDX_LAST) begin
                        state_n    = DONE;
                        all_pass_n = (fail_n == '0) && (to_n == '0);
                    end else begin
                        idx_n   = cur_idx + IW'(1);
                        state_n = (GAP_CYCLES == 0) ? START : GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = START;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up
    // with the state they describe.
    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            unit_start  <= '0;
            busy        <= 1'b0;
            finish      <= 1'b0;
            all_pass    <= 1'b0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            timeout_cnt <= '0;
            fail_vec    <= '0;
            cur_idx     <= '0;
        end else begin
            state       <= state_n;
            gap_cnt     <= (state == GAP) ? gap_cnt + GW'(1) : '0;
            unit_start  <= (state_n == START) ?
                           (NUM_UNITS'(1) << idx_n) : '0;
            busy        <= (state_n != IDLE);
            finish      <= (state_n == DONE);
            all_pass    <= all_pass_n;
            pass_cnt    <= pass_n;
            fail_cnt    <= fail_n;
            timeout_cnt <= to_n;
            fail_vec    <= vec_n;
            cur_idx     <= idx_n;
        end
    end

endmodule

// File: tb/tb_test_unit_seq.sv
// Directed bench for test_unit_seq: two instances (GAP=2 and GAP=0),
// a cycle-stepped unit responder and hand-computed expectations.
module tb_test_unit_seq;

    localparam int N  = 4;
    localparam int TO = 10;
    localparam int CW = $clog2(N + 1);
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int sel;
    logic rst_all, rst_v, run_v;
    logic [N-1:0] done_v, pass_v;

    logic rst_a, rst_b, run_a, run_b;
    logic [N-1:0] done_a, done_b, pass_a, pass_b;
    logic [N-1:0] start_a, start_b, vec_a, vec_b;
    logic busy_a, busy_b, fin_a, fin_b, allp_a, allp_b;
    logic [CW-1:0] pc_a, pc_b, fc_a, fc_b, tc_a, tc_b;
    logic [IW-1:0] idx_a, idx_b;

    assign rst_a  = rst_all | ((sel == 0) & rst_v);
    assign rst_b  = rst_all | ((sel == 1) & rst_v);
    assign run_a  = (sel == 0) & run_v;
    assign run_b  = (sel == 1) & run_v;
    assign done_a = (sel == 0) ? done_v : '0;
    assign done_b = (sel == 1) ? done_v : '0;
    assign pass_a = (sel == 0) ? pass_v : '0;
    assign pass_b = (sel == 1) ? pass_v : '0;

    test_unit_seq #(
        .NUM_UNITS(N), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(2)
    ) dut_a (
        .clock(clk), .rst(rst_a), .run(run_a),
        .unit_start(start_a), .unit_done(done_a), .unit_pass(pass_a),
        .busy(busy_a), .finish(fin_a), .all_pass(allp_a),
        .pass_cnt(pc_a), .fail_cnt(fc_a), .timeout_cnt(tc_a),
        .fail_vec(vec_a), .cur_idx(idx_a)
    );

    test_unit_seq #(
        .NUM_UNITS(N), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(0)
    ) dut_b (
        .clock(clk), .rst(rst_b), .run(run_b),
        .unit_start(start_b), .unit_done(done_b), .unit_pass(pass_b),
        .busy(busy_b), .finish(fin_b), .all_pass(allp_b),
        .pass_cnt(pc_b), .fail_cnt(fc_b), .timeout_cnt(tc_b),
        .fail_vec(vec_b), .cur_idx(idx_b)
    );

    logic [N-1:0] o_start, o_vec;
    logic o_busy, o_fin, o_allp;
    logic [CW-1:0] o_pc, o_fc, o_tc;
    logic [IW-1:0] o_idx;

    assign o_start = sel ? start_b : start_a;
    assign o_vec   = sel ? vec_b : vec_a;
    assign o_busy  = sel ? busy_b : busy_a;
    assign o_fin   = sel ? fin_b : fin_a;
    assign o_allp  = sel ? allp_b : allp_a;
    assign o_pc    = sel ? pc_b : pc_a;
    assign o_fc    = sel ? fc_b : fc_a;
    assign o_tc    = sel ? tc_b : tc_a;
    assign o_idx   = sel ? idx_b : idx_a;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Responder configuration.
    int dly[N];
    bit pss[N];
    bit nev[N];
    int hold[N];
    int stray_cyc, rerun_cyc;
    bit rst_in_u1;

    // Run results.
    int st[N];
    int n_starts, n_fin, fin_cyc, idx2_cyc, rst_cyc, starts_after;
    logic [31:0] r_pc, r_fc, r_tc, r_vec, r_allp, r_busy, r_idx;
    logic [31:0] a_busy, a_allp, p_busy, p_idx;
    logic [31:0] s_start, s_busy, s_fin, s_allp, s_pc, s_vec, s_idx;

    task automatic cfg_default();
        for (int i = 0; i < N; i++) begin
            dly[i]  = 3;
            pss[i]  = 1'b1;
            nev[i]  = 1'b0;
            hold[i] = 1;
        end
        stray_cyc = -1;
        rerun_cyc = -1;
        rst_in_u1 = 1'b0;
    endtask

    task automatic run_seq(input int max_cyc);
        int cyc;
        n_starts = 0; n_fin = 0; fin_cyc = -1; idx2_cyc = -1;
        rst_cyc = -1; starts_after = 0;
        for (int i = 0; i < N; i++) st[i] = -1;
        p_busy = '0; p_idx = '0;
        @(negedge clk);
        run_v = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (cyc < max_cyc && !(n_fin > 0 && cyc > fin_cyc + 2)) begin
            for (int i = 0; i < N; i++) begin
                if (o_start[i]) begin
                    n_starts++;
                    if (st[i] < 0) st[i] = cyc;
                end
            end
            if (rst_cyc >= 0 && o_start != '0) starts_after++;
            if (o_idx == 2'd2 && idx2_cyc < 0) idx2_cyc = cyc;
            if (st[1] >= 0 && cyc == st[1] + 30) begin
                p_busy = 32'(o_busy);
                p_idx  = 32'(o_idx);
            end
            if (o_fin) begin
                n_fin++;
                fin_cyc = cyc;
                r_pc = 32'(o_pc); r_fc = 32'(o_fc); r_tc = 32'(o_tc);
                r_vec = 32'(o_vec); r_allp = 32'(o_allp);
                r_busy = 32'(o_busy); r_idx = 32'(o_idx);
            end
            if (n_fin > 0 && cyc == fin_cyc + 1) begin
                a_busy = 32'(o_busy);
                a_allp = 32'(o_allp);
            end
            if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
                s_start = 32'(o_start); s_busy = 32'(o_busy);
                s_fin = 32'(o_fin); s_allp = 32'(o_allp);
                s_pc = 32'(o_pc); s_vec = 32'(o_vec); s_idx = 32'(o_idx);
            end
            done_v = '0; pass_v = '0; run_v = 1'b0; rst_v = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (st[i] >= 0 && !nev[i] && cyc >= st[i] + dly[i] &&
                    cyc < st[i] + dly[i] + hold[i]) begin
                    done_v[i] = 1'b1;
                    pass_v[i] = pss[i];
                end
            end
            if (cyc == stray_cyc) begin
                done_v[3] = 1'b1;
                pass_v[3] = 1'b0;
            end
            if (cyc == rerun_cyc) run_v = 1'b1;
            if (rst_in_u1 && st[1] >= 0 && cyc == st[1] + 1) begin
                rst_v = 1'b1;
                rst_cyc = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        done_v = '0; pass_v = '0; run_v = 1'b0; rst_v = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        sel = 0; rst_all = 1'b1; rst_v = 1'b0; run_v = 1'b0;
        done_v = '0; pass_v = '0;
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(start_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_finish", 32'(fin_a), 0);
        chk("rst_allpass", 32'(allp_a), 0);
        chk("rst_cnts", {pc_a, fc_a, tc_a}, 0);
        chk("rst_vec_idx", {vec_a, idx_a}, 0);
        rst_all = 1'b0;
        @(negedge clk);

        // All units pass.
        cfg_default();
        run_seq(120);
        chk("t1_first_start", st[0], 0);
        chk("t1_starts", n_starts, 4);
        chk("t1_finish_pulses", n_fin, 1);
        chk("t1_pass", r_pc, 4);
        chk("t1_fail_to", {r_fc, r_tc}, 0);
        chk("t1_vec", r_vec, 0);
        chk("t1_allpass", r_allp, 1);
        chk("t1_busy_at_fin", r_busy, 1);
        chk("t1_idx_at_fin", r_idx, 3);
        chk("t1_busy_after", a_busy, 0);
        chk("t1_allpass_sticky", a_allp, 1);

        // Unit 2 fails.
        cfg_default();
        pss[2] = 1'b0;
        run_seq(120);
        chk("t2_pass", r_pc, 3);
        chk("t2_fail", r_fc, 1);
        chk("t2_vec", r_vec, 4'b0100);
        chk("t2_allpass", r_allp, 0);

        // Unit 1 never answers.
        cfg_default();
`ifdef TEST_UNIT_SEQ_TIMEOUT_EN
        nev[1] = 1'b1;
        run_seq(120);
        chk("t3_wait_len", idx2_cyc - st[1] - 1, TO);
        chk("t3_timeout", r_tc, 1);
        chk("t3_fail", r_fc, 0);
        chk("t3_pass", r_pc, 3);
        chk("t3_vec", r_vec, 4'b0010);
        chk("t3_allpass", r_allp, 0);
`else
        dly[1] = 35;
        pss[1] = 1'b0;
        run_seq(160);
        chk("t3_busy_held", p_busy, 1);
        chk("t3_idx_held", p_idx, 1);
        chk("t3_timeout", r_tc, 0);
        chk("t3_fail", r_fc, 1);
        chk("t3_vec", r_vec, 4'b0010);
        chk("t3_allpass", r_allp, 0);
`endif

        // Done in the last wait cycle of unit 0.
        cfg_default();
        dly[0] = TO;
        run_seq(120);
        chk("t4_pass", r_pc, 4);
        chk("t4_timeout", r_tc, 0);
        chk("t4_allpass", r_allp, 1);

        // Stray done, level-held done, run while busy.
        cfg_default();
        stray_cyc = 1;
        rerun_cyc = 5;
        hold[1]   = 4;
        run_seq(120);
        chk("t5_starts", n_starts, 4);
        chk("t5_finish_pulses", n_fin, 1);
        chk("t5_pass", r_pc, 4);
        chk("t5_fail", r_fc, 0);
        chk("t5_vec", r_vec, 0);

        // Zero gap instance.
        sel = 1;
        cfg_default();
        dly = '{2, 2, 2, 2};
        run_seq(120);
        chk("t6_gap0_1", st[1] - st[0], 3);
        chk("t6_gap0_3", st[3] - st[2], 3);
        chk("t6_pass", r_pc, 4);
        chk("t6_allpass", r_allp, 1);

        // Reset during unit 1 wait.
        cfg_default();
        dly = '{2, 2, 2, 2};
        rst_in_u1 = 1'b1;
        run_seq(30);
        chk("t7_rst_seen", rst_cyc, st[1] + 1);
        chk("t7_start", s_start, 0);
        chk("t7_busy", s_busy, 0);
        chk("t7_fin", s_fin, 0);
        chk("t7_allpass", s_allp, 0);
        chk("t7_pass", s_pc, 0);
        chk("t7_vec_idx", {s_vec, s_idx}, 0);
        chk("t7_no_restart", starts_after, 0);
        chk("t7_no_finish", n_fin, 0);

        // Fresh run after reset.
        cfg_default();
        dly = '{2, 2, 2, 2};
        run_seq(120);
        chk("t8_first_start", st[0], 0);
        chk("t8_pass", r_pc, 4);
        chk("t8_allpass", r_allp, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
